// File: rtl/seg_disp_arb.sv
// Four-way round-robin arbiter feeding an 8-digit hex 7-segment shift chain.
// Each grant captures one 32-bit word, serialises a 64-bit frame, then holds it for DWELL cycles.
module seg_disp_arb #(
  parameter int unsigned CLKDIV = 2,
  parameter int unsigned DWELL  = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  input  logic [127:0] req_data,
  input  logic [31:0]  req_dot,
  output logic [3:0]   req_ready,
  output logic         SEGCLK,
  output logic         SEGCLR,
  output logic         SEGDT,
  output logic         SEGEN,
  output logic         busy,
  output logic [1:0]   cur_src
);

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned DWELL_W = 24;
  localparam int unsigned BIT_W   = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DWELL = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           cur_src_q, cur_src_d;
  logic [3:0]           ready_q, ready_d;
  logic [63:0]          frame_q, frame_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 first_q, first_d;
  logic                 segclk_q, segclk_d;
  logic                 segdt_q, segdt_d;
  logic                 segen_q, segen_d;
  logic                 segclr_q, segclr_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [1:0]           gnt;
  logic [1:0]           idx;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] encode(input logic [31:0] w, input logic [7:0] dm);
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) begin
      f[8*k +: 8] = {~dm[k], seg7(w[4*k +: 4])};
    end
    return f;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cur_src_q <= '0;
      ready_q   <= '0;
      frame_q   <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      dwell_q   <= '0;
      first_q   <= 1'b0;
      segclk_q  <= 1'b0;
      segdt_q   <= 1'b0;
      segen_q   <= 1'b0;
      segclr_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cur_src_q <= cur_src_d;
      ready_q   <= ready_d;
      frame_q   <= frame_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      dwell_q   <= dwell_d;
      first_q   <= first_d;
      segclk_q  <= segclk_d;
      segdt_q   <= segdt_d;
      segen_q   <= segen_d;
      segclr_q  <= segclr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cur_src_d = cur_src_q;
    ready_d   = '0;
    frame_d   = frame_q;
    div_d     = div_q;
    bit_d     = bit_q;
    dwell_d   = dwell_q;
    first_d   = 1'b0;
    segclk_d  = segclk_q;
    segdt_d   = segdt_q;
    segen_d   = segen_q;
    segclr_d  = 1'b1;
    found     = 1'b0;
    gnt       = ptr_q;
    idx       = '0;

    // Round-robin search starting at ptr.
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d   = ST_LOAD;
          ptr_d     = gnt + 2'd1;
          cur_src_d = gnt;
          ready_d   = 4'b0001 << gnt;
          frame_d   = encode(req_data[{gnt, 5'd0} +: 32], req_dot[{gnt, 3'd0} +: 8]);
        end
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
        first_d = 1'b1;
      end
      ST_SHIFT: begin
        // First cycle only presents bit 63; each bit then spends CLKDIV low and CLKDIV high.
        if (first_q) begin
          segdt_d  = frame_q[63];
          segclk_d = 1'b0;
          div_d    = '0;
          bit_d    = '0;
        end else if (div_q == DIV_W'(CLKDIV - 1)) begin
          div_d = '0;
          if (!segclk_q) begin
            segclk_d = 1'b1;
          end else begin
            segclk_d = 1'b0;
            if (bit_q == BIT_W'(63)) begin
              state_d = ST_DWELL;
              segen_d = 1'b1;
              dwell_d = '0;
            end else begin
              bit_d   = bit_q + 6'd1;
              frame_d = {frame_q[62:0], 1'b0};
              segdt_d = frame_q[62];
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_DWELL: begin
        if (dwell_q == DWELL_W'(DWELL - 1)) begin
          state_d = ST_IDLE;
        end else begin
          dwell_d = dwell_q + 24'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign req_ready = ready_q;
  assign SEGCLK    = segclk_q;
  assign SEGCLR    = segclr_q;
  assign SEGDT     = segdt_q;
  assign SEGEN     = segen_q;
  assign busy      = busy_q;
  assign cur_src   = cur_src_q;

endmodule

// File: tb/tb_seg_disp_arb.sv
// Directed bench for seg_disp_arb: reset values, round-robin order, frame encoding,
// shift timing, dwell-based re-arbitration and asynchronous abort.
module tb_seg_disp_arb;

  localparam int unsigned CLKDIV = 2;
  localparam int unsigned DWELL  = 10;
  // ready sample (LOAD) -> first DWELL cycle: LOAD + latency cycle + 128*CLKDIV
  localparam int SEGEN_LAT = 2 + 128 * CLKDIV;
  localparam int IDLE_LAT  = SEGEN_LAT + DWELL;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [31:0]  req_dot;
  logic [3:0]   req_ready;
  logic         SEGCLK, SEGCLR, SEGDT, SEGEN, busy;
  logic [1:0]   cur_src;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  seg_disp_arb #(.CLKDIV(CLKDIV), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_dot(req_dot),
    .req_ready(req_ready), .SEGCLK(SEGCLK), .SEGCLR(SEGCLR), .SEGDT(SEGDT), .SEGEN(SEGEN),
    .busy(busy), .cur_src(cur_src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [7:0]  dot;
    logic [1:0]  gnt;
    logic [63:0] frame;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      if (req_ready != 4'b0000) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: no ready within %0d cycles", max);
    end
  endtask

  task automatic wait_idle(input int max);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      step();
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still high after %0d cycles", max);
    end
  endtask

  // Collect SEGDT on each SEGCLK rise until busy drops; optionally raise extra valids mid-frame.
  task automatic capture(input int max, input int inject_at, input logic [3:0] inject,
                         output logic [63:0] bits, output int rises,
                         output int t_segen, output int t_idle);
    logic prev_clk;
    logic prev_en;
    prev_clk = SEGCLK;
    prev_en  = SEGEN;
    bits     = '0;
    rises    = 0;
    t_segen  = -1;
    t_idle   = -1;
    for (int i = 0; i < max; i++) begin
      step();
      if (i == inject_at) req_valid = req_valid | inject;
      if (SEGCLK && !prev_clk) begin
        bits = {bits[62:0], SEGDT};
        rises++;
      end
      if (SEGEN && !prev_en && t_segen < 0) t_segen = cyc;
      prev_clk = SEGCLK;
      prev_en  = SEGEN;
      if (!busy) begin
        t_idle = cyc;
        break;
      end
    end
    if (t_idle < 0) begin
      checks++;
      errors++;
      $display("FAIL capture: frame did not finish within %0d cycles", max);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},  64'(req_ready), 64'h0);
    chk({tag, "_segclk"}, 64'(SEGCLK),    64'h0);
    chk({tag, "_segdt"},  64'(SEGDT),     64'h0);
    chk({tag, "_segclr"}, 64'(SEGCLR),    64'h0);
    chk({tag, "_segen"},  64'(SEGEN),     64'h0);
    chk({tag, "_busy"},   64'(busy),      64'h0);
    chk({tag, "_cursrc"}, 64'(cur_src),   64'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ok;
    logic [63:0] bits;
    int          rises, t_segen, t_idle, t0, t1, t2;
    int          n_busy, n_clk, n_en;
    logic [1:0]  e;

    vecs[0] = '{4'b0001, 32'h0123ABCD, 8'h00, 2'd0, 64'hC0F9A4B0_8883C6A1};
    vecs[1] = '{4'b0010, 32'h80000000, 8'h80, 2'd1, 64'h00C0C0C0_C0C0C0C0};
    vecs[2] = '{4'b0100, 32'h456789EF, 8'h01, 2'd2, 64'h999282F8_8090860E};
    vecs[3] = '{4'b1000, 32'hFFFFFFFF, 8'hFF, 2'd3, 64'h0E0E0E0E_0E0E0E0E};
    vecs[4] = '{4'b0001, 32'h00000000, 8'h55, 2'd0, 64'hC040C040_C040C040};

    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_dot   = '0;
    repeat (3) step();
    check_reset_outputs("rst");
    rst = 1'b1;
    step();
    chk("segclr_rise", 64'(SEGCLR), 64'h1);

    // All four requesters held valid: grants rotate 0,1,2,3,0.
    req_data  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      e = 2'(g);
      wait_ready(IDLE_LAT + 40, ok);
      chk($sformatf("rr_ready_%0d", g), 64'(req_ready), 64'(4'b0001 << e));
      chk($sformatf("rr_src_%0d", g),   64'(cur_src),   64'(e));
      step();
      chk($sformatf("rr_pulse_%0d", g), 64'(req_ready), 64'h0);
    end
    req_valid = '0;
    wait_idle(IDLE_LAT + 40);

    // Table of single-requester frames.
    for (int v = 0; v < 5; v++) begin
      for (int s = 0; s < 4; s++) begin
        req_data[32*s +: 32] = vecs[v].valid[s] ? vecs[v].data : 32'h5A5A5A5A;
        req_dot[8*s +: 8]    = vecs[v].valid[s] ? vecs[v].dot  : 8'hA5;
      end
      req_valid = vecs[v].valid;
      wait_ready(20, ok);
      t0 = cyc;
      chk($sformatf("v%0d_ready", v),  64'(req_ready), 64'(4'b0001 << vecs[v].gnt));
      chk($sformatf("v%0d_src", v),    64'(cur_src),   64'(vecs[v].gnt));
      req_valid = '0;
      capture(IDLE_LAT + 100, -1, 4'b0000, bits, rises, t_segen, t_idle);
      chk($sformatf("v%0d_frame", v),  bits,           vecs[v].frame);
      chk($sformatf("v%0d_rises", v),  64'(rises),     64'd64);
      chk($sformatf("v%0d_len", v),    64'(t_idle - t0), 64'(IDLE_LAT));
      chk($sformatf("v%0d_segen", v),  64'(SEGEN),     64'h1);
    end

    // Long idle: display stays enabled, shift clock static.
    n_busy = 0;
    n_clk  = 0;
    n_en   = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (busy)   n_busy++;
      if (SEGCLK) n_clk++;
      if (!SEGEN) n_en++;
    end
    chk("idle_busy_cycles",   64'(n_busy), 64'h0);
    chk("idle_segclk_cycles", 64'(n_clk),  64'h0);
    chk("idle_segen_low",     64'(n_en),   64'h0);

    // Reset in the middle of a frame from requester 3.
    req_data[127:96] = 32'h12345678;
    req_dot[31:24]   = 8'h00;
    req_valid        = 4'b1000;
    wait_ready(20, ok);
    chk("abort_src", 64'(cur_src), 64'd3);
    req_valid = '0;
    rises = 0;
    begin
      logic prev_clk;
      prev_clk = SEGCLK;
      for (int i = 0; i < 300 && rises < 30; i++) begin
        step();
        if (SEGCLK && !prev_clk) rises++;
        prev_clk = SEGCLK;
      end
    end
    chk("abort_reached_bit30", 64'(rises), 64'd30);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    step();
    step();
    rst = 1'b1;
    step();
    chk("abort_segclr_rise", 64'(SEGCLR), 64'h1);

    // Fresh frame after abort; requester 2 arrives mid-shift and waits for DWELL + IDLE.
    req_data[63:32] = 32'hCAFEF00D;
    req_dot[15:8]   = 8'h00;
    req_data[95:64] = 32'h00000000;
    req_valid       = 4'b0010;
    wait_ready(20, ok);
    t1 = cyc;
    chk("late_ready1", 64'(req_ready), 64'h2);
    req_valid = '0;
    capture(IDLE_LAT + 100, 100, 4'b0100, bits, rises, t_segen, t_idle);
    chk("late_frame1",    bits,               64'hC6888E86_8EC0C0A1);
    chk("late_rises1",    64'(rises),         64'd64);
    chk("late_segen_lat", 64'(t_segen - t1),  64'(SEGEN_LAT));
    wait_ready(20, ok);
    t2 = cyc;
    chk("late_ready2",    64'(req_ready),     64'h4);
    chk("late_src2",      64'(cur_src),       64'd2);
    chk("late_from_dwell", 64'(t2 - t_segen), 64'(DWELL + 1));
    chk("late_regrant",   64'(t2 - t1),       64'(3 + 128 * CLKDIV + DWELL));
    req_valid = '0;
    wait_idle(IDLE_LAT + 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
